data_memory_responder: RTL

DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

---
 rtl/data_memory_responder.sv | 96 +++++++++
 1 files changed

// File: rtl/data_memory_responder.sv
// Single-port word memory behind a valid/ready request channel.
// Each accepted request spends LATENCY cycles in BUSY, then produces a
// one-cycle response in RESP before the responder is ready again.
module data_memory_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;

  logic [31:0] mem [DEPTH];

  logic          fault;
  logic [AW-1:0] idx;
  logic          finish;

  assign idx    = cap_addr[AW+1:2];
  assign fault  = (cap_addr[1:0] != 2'b00) || ({2'b00, cap_addr[31:2]} >= 32'(DEPTH));
  // Last BUSY edge: the access itself happens here.
  assign finish = (state == BUSY) && (cnt == 4'd0);

  // Ready is gated by rst so it reads 0 while reset is held, even though
  // the state register already sits in IDLE.
  assign req_ready = (state == IDLE) && !rst;
  assign busy      = (state != IDLE);

  // Control FSM, request capture and registered response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      cap_write  <= 1'b0;
      cap_addr   <= 32'd0;
      cap_wdata  <= 32'd0;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state     <= BUSY;
            cnt       <= 4'(LATENCY - 1);
            cap_write <= req_write;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_error <= fault;
            resp_rdata <= (fault || cap_write) ? 32'd0 : mem[idx];
          end
        end
        RESP: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_rdata <= 32'd0;
          resp_error <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Array write port; no reset so contents survive rst.
  always_ff @(posedge clk) begin
    if (!rst && finish && cap_write && !fault)
      mem[idx] <= cap_wdata;
  end

endmodule
